// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: rebuilds pixel coordinates from incoming hsync/vsync and tracks mode lock
module vga_sync_decoder #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_active,
    output logic       frame_start,
    output logic       locked,
    output logic [7:0] err_count
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_MAX  = 11'(2 * H_TOTAL);
    localparam logic [10:0] X0     = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] X1     = 11'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  Y0     = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  Y1     = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [3:0]  LF     = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t      state;
    logic [3:0]  good_frames;
    logic        hs1, hs2, hs_prev, vs1, vs2, vs_prev;
    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        v_pend;
    logic        h_edge, v_edge, v_rst, bad_line, drop, in_win, show;

    assign h_edge   = hs_prev & ~hs2;
    assign v_edge   = vs_prev & ~vs2;
    assign v_rst    = h_edge & (v_pend | v_edge);
    assign bad_line = h_edge ? (h_cnt != H_LAST) : (h_cnt == H_MAX);
    assign drop     = (state != SEARCH) && (bad_line || (v_rst && v_cnt != V_LAST));
    assign in_win   = (h_cnt >= X0) && (h_cnt <= X1) && (v_cnt >= Y0) && (v_cnt <= Y1);
    assign show     = (state == LOCKED) && !drop && in_win;

    // two-flop synchronizer plus previous-value stage for falling-edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {hs1, hs2, hs_prev} <= 3'b111;
            {vs1, vs2, vs_prev} <= 3'b111;
        end else begin
            {hs1, hs2, hs_prev} <= {hsync, hs1, hs2};
            {vs1, vs2, vs_prev} <= {vsync, vs1, vs2};
        end
    end

    // position counters; a vsync edge waits for the next hsync edge to restart the frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt  <= '0;
            v_cnt  <= '0;
            v_pend <= 1'b0;
        end else begin
            h_cnt  <= h_edge ? 11'd0 : (h_cnt == H_MAX ? h_cnt : h_cnt + 11'd1);
            if (h_edge)
                v_cnt <= v_rst ? 10'd0 : (v_cnt == 10'h3FF ? v_cnt : v_cnt + 10'd1);
            v_pend <= v_rst ? 1'b0 : (v_pend | v_edge);
        end
    end

    // lock state machine with registered coordinate and status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= SEARCH;
            good_frames  <= '0;
            locked       <= 1'b0;
            frame_start  <= 1'b0;
            err_count    <= '0;
            video_active <= 1'b0;
            pixel_x      <= '0;
            pixel_y      <= '0;
        end else begin
            frame_start  <= 1'b0;
            video_active <= show;
            pixel_x      <= show ? 10'(h_cnt - X0) : 10'd0;
            pixel_y      <= show ? (v_cnt - Y0) : 10'd0;
            case (state)
                SEARCH: if (v_rst) begin
                    state       <= VERIFY;
                    good_frames <= '0;
                end
                VERIFY: if (drop) begin
                    state <= SEARCH;
                end else if (v_rst) begin
                    good_frames <= good_frames + 4'd1;
                    if (good_frames + 4'd1 == LF) begin
                        state       <= LOCKED;
                        locked      <= 1'b1;
                        frame_start <= 1'b1;
                    end
                end
                LOCKED: begin
                    frame_start <= v_rst;
                    if (drop) begin
                        state     <= SEARCH;
                        locked    <= 1'b0;
                        err_count <= err_count + {7'd0, err_count != 8'hFF};
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed streams in a reduced video mode checked by a frame-level model
module tb_vga_sync_decoder;
    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 2, VF = 1, VS = 1, VB = 1;
    localparam int LF = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic clk = 1'b0, rst_n = 1'b0, hsync = 1'b1, vsync = 1'b1;
    logic [9:0] pixel_x, pixel_y;
    logic video_active, frame_start, locked;
    logic [7:0] err_count;

    int tests = 0, fails = 0;
    int sc = 0, lock_at = -1, fs_cnt = 0, fs_gap = 0, fs_last = 0;
    int ph[4], pv[4];
    logic probe = 1'b0, mon = 1'b0;

    int d1h, d2h, d3h, d1v, d2v, d3v, age, vl, vp, bnd, merr;
    int hf, vf, vr, bad, fbad, dis, lk, win;
    int e_x, e_y, e_act, e_fs, e_lk, e_err;

    always #5 clk = ~clk;

    vga_sync_decoder #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                       .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                       .LOCK_FRAMES(LF)) dut (
        .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_active(video_active),
        .frame_start(frame_start), .locked(locked), .err_count(err_count));

    // frame-level model: bnd counts clean frame boundaries since the last disruption
    always @(posedge clk) begin
        if (!rst_n) begin
            d1h = 1; d2h = 1; d3h = 1; d1v = 1; d2v = 1; d3v = 1;
            age = 0; vl = 0; vp = 0; bnd = 0; merr = 0;
            e_x = 0; e_y = 0; e_act = 0; e_fs = 0; e_lk = 0; e_err = 0;
        end else begin
            hf   = (d3h == 1 && d2h == 0) ? 1 : 0;
            vf   = (d3v == 1 && d2v == 0) ? 1 : 0;
            vr   = (hf == 1 && (vp == 1 || vf == 1)) ? 1 : 0;
            lk   = (bnd > LF) ? 1 : 0;
            bad  = (bnd > 0 && (hf == 1 ? age != HT - 1 : age == 2 * HT)) ? 1 : 0;
            fbad = (bnd > 0 && vr == 1 && vl != VT - 1) ? 1 : 0;
            dis  = (bad == 1 || fbad == 1) ? 1 : 0;
            win  = (age >= HS + HB && age < HS + HB + HA && vl >= VS + VB && vl < VS + VB + VA) ? 1 : 0;
            e_act = (lk == 1 && dis == 0 && win == 1) ? 1 : 0;
            e_x   = e_act == 1 ? age - (HS + HB) : 0;
            e_y   = e_act == 1 ? vl - (VS + VB) : 0;
            e_fs  = (vr == 1 && (lk == 1 || (dis == 0 && bnd == LF))) ? 1 : 0;
            if (dis == 1) begin
                if (lk == 1 && merr < 255) merr = merr + 1;
                bnd = 0;
            end else if (vr == 1 && bnd <= LF) bnd = bnd + 1;
            e_lk  = (bnd > LF) ? 1 : 0;
            e_err = merr;
            if (hf == 1) vl = vr == 1 ? 0 : (vl < 1023 ? vl + 1 : vl);
            age = hf == 1 ? 0 : (age < 2 * HT ? age + 1 : age);
            vp  = vr == 1 ? 0 : (vf == 1 ? 1 : vp);
            d3h = d2h; d2h = d1h; d1h = int'(hsync);
            d3v = d2v; d2v = d1v; d1v = int'(vsync);
        end
    end

    // compare every output against the model between clock edges
    always @(negedge clk) begin
        if (mon) begin
            tests = tests + 1;
            if (int'(pixel_x) != e_x || int'(pixel_y) != e_y || int'(video_active) != e_act ||
                int'(frame_start) != e_fs || int'(locked) != e_lk || int'(err_count) != e_err) begin
                fails = fails + 1;
                $display("FAIL model t=%0t dut/model x=%0d/%0d y=%0d/%0d act=%0d/%0d fs=%0d/%0d lk=%0d/%0d err=%0d/%0d",
                         $time, pixel_x, e_x, pixel_y, e_y, video_active, e_act,
                         frame_start, e_fs, locked, e_lk, err_count, e_err);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests = tests + 1;
        if (act != exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int h, input int v, input int hs, input int vs);
        int k;
        hsync = (hs != 0);
        vsync = (vs != 0);
        @(posedge clk);
        @(negedge clk);
        ph[sc % 4] = h;
        pv[sc % 4] = v;
        k = (sc + 1) % 4;
        if (probe) begin
            if (pv[k] == 2 && ph[k] == 3) begin
                check("first_px_x", int'(pixel_x), 0);
                check("first_px_y", int'(pixel_y), 0);
                check("first_px_act", int'(video_active), 1);
            end
            if (pv[k] == 3 && ph[k] == 6) begin
                check("last_px_x", int'(pixel_x), 3);
                check("last_px_y", int'(pixel_y), 1);
                check("last_px_act", int'(video_active), 1);
            end
            if (pv[k] == 3 && ph[k] == 7) begin
                check("past_px_act", int'(video_active), 0);
                check("past_px_x", int'(pixel_x), 0);
            end
        end
        if (locked && lock_at < 0) lock_at = sc;
        if (frame_start) begin
            fs_cnt  = fs_cnt + 1;
            fs_gap  = sc - fs_last;
            fs_last = sc;
        end
        sc = sc + 1;
    endtask

    task automatic src_line(input int v, input int len, input int vearly);
        for (int h = 0; h < len; h++)
            drive(h, v, h >= HS, !(v < VS || (vearly >= 0 && v == VT - 1 && h >= vearly)));
    endtask

    task automatic src_frame(input int nlines, input int short_ln, input int vearly);
        for (int v = 0; v < nlines; v++)
            src_line(v, v == short_ln ? HT - 1 : HT, vearly);
    endtask

    initial begin
        @(negedge clk);
        drive(-1, -1, 1, 1);
        mon = 1'b1;
        drive(-1, -1, 1, 1);
        check("rst_locked", int'(locked), 0);
        check("rst_err", int'(err_count), 0);
        check("rst_act", int'(video_active), 0);
        check("rst_x", int'(pixel_x), 0);
        check("rst_fs", int'(frame_start), 0);
        rst_n = 1'b1;
        sc = 0;
        repeat (5) src_frame(VT, -1, -1);
        check("lock_sample", lock_at, 82);
        check("fs_count", fs_cnt, 3);
        check("fs_period", fs_gap, HT * VT);
        check("err_clean", int'(err_count), 0);

        probe = 1'b1;
        src_frame(VT, -1, -1);
        probe = 1'b0;

        src_line(0, HT, -1);
        src_line(1, HT, -1);
        src_line(2, HT - 1, -1);
        for (int h = 0; h < HT; h++) begin
            drive(h, 3, h >= HS, 1);
            if (h == 1) check("short_before", int'(locked), 1);
            if (h == 2) begin
                check("short_after", int'(locked), 0);
                check("short_err", int'(err_count), 1);
            end
        end
        src_line(4, HT, -1);
        repeat (2) src_frame(VT, -1, -1);
        check("relock_early", int'(locked), 0);
        src_frame(VT, -1, -1);
        check("relock", int'(locked), 1);

        src_line(0, HT, -1);
        for (int k = 0; k < 60; k++) begin
            drive(-1, -1, k >= HS, 1);
            if (k == 2 * HT + 2) check("timeout_before", int'(locked), 1);
            if (k == 2 * HT + 3) check("timeout_after", int'(locked), 0);
        end
        check("timeout_err", int'(err_count), 2);

        src_frame(VT - 1, -1, -1);
        repeat (3) src_frame(VT, -1, -1);
        check("short_frame_locked", int'(locked), 0);
        check("short_frame_err", int'(err_count), 2);
        src_frame(VT, -1, -1);
        check("short_frame_relock", int'(locked), 1);

        src_frame(VT, -1, 3);
        probe = 1'b1;
        src_frame(VT, -1, -1);
        probe = 1'b0;
        check("early_v_locked", int'(locked), 1);
        check("early_v_err", int'(err_count), 2);

        src_line(0, HT, -1);
        src_line(1, HT, -1);
        for (int h = 0; h < 5; h++) drive(h, 2, h >= HS, 1);
        rst_n = 1'b0;
        drive(5, 2, 1, 1);
        rst_n = 1'b1;
        check("midrst_locked", int'(locked), 0);
        check("midrst_err", int'(err_count), 0);
        check("midrst_act", int'(video_active), 0);
        check("midrst_x", int'(pixel_x), 0);
        check("midrst_y", int'(pixel_y), 0);
        check("midrst_fs", int'(frame_start), 0);
        for (int h = 6; h < HT; h++) drive(h, 2, h >= HS, 1);
        src_line(3, HT, -1);
        src_line(4, HT, -1);
        repeat (2) src_frame(VT, -1, -1);
        check("midrst_relock_early", int'(locked), 0);
        src_frame(VT, -1, -1);
        check("midrst_relock", int'(locked), 1);

        for (int i = 0; i < 256; i++) begin
            src_frame(VT, 2, -1);
            repeat (2) src_frame(VT, -1, -1);
        end
        src_frame(VT, -1, -1);
        check("err_saturate", int'(err_count), 255);
        check("sat_relock", int'(locked), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
